// File: rtl/image_write_stream.sv
// ---------------------------------------------------------------------------
// image_write_stream
//
// Takes a stream of RGB pixel beats and writes them one byte at a time into a
// byte-addressed memory in BMP pixel-array layout. Each row is laid out with a
// 4-byte-aligned stride. The pixel array begins at HDR_BYTES. When BOTTOM_UP=1
// the rows are stored bottom-up.
//
// Ports
//   HCLK         clock, rising edge
//   HRESETn      synchronous active-low reset
//   start        frame-start pulse, acted on only when idle
//   pix_valid    input beat valid
//   pix_data     PIX_PER_BEAT pixels, pixel k at [24k+23:24k], R/G/B = [23:16]/[15:8]/[7:0]
//   pix_ready    high while waiting for a beat
//   mem_we       byte write strobe
//   mem_addr     byte address (holds when mem_we=0)
//   mem_wdata    byte data    (holds when mem_we=0)
//   busy         high whenever a frame is in progress
//   frame_done   one-cycle pulse at the end of a frame
//   frame_count  completed frames, wraps at 16 bits
// ---------------------------------------------------------------------------
module image_write_stream #(
    parameter int WIDTH        = 768,
    parameter int HEIGHT       = 512,
    parameter int PIX_PER_BEAT = 2,
    parameter int BOTTOM_UP    = 1,
    parameter int HDR_BYTES    = 54,
    parameter int ADDR_W       = 22
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      start,
    input  logic                      pix_valid,
    input  logic [24*PIX_PER_BEAT-1:0] pix_data,
    output logic                      pix_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [7:0]                mem_wdata,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);

    localparam int BYTES_PER_BEAT = 3 * PIX_PER_BEAT;
    localparam int ROW_BYTES      = WIDTH * 3;
    localparam int STRIDE         = ((ROW_BYTES + 3) / 4) * 4;
    localparam int PAD_BYTES      = STRIDE - ROW_BYTES;
    localparam int BEATS_PER_ROW  = WIDTH / PIX_PER_BEAT;
    localparam int BIDX_W         = $clog2(BYTES_PER_BEAT + 1);
    localparam int BEAT_W         = $clog2(BEATS_PER_ROW + 1);
    localparam int ROW_W          = $clog2(HEIGHT + 1);
    localparam int COL_W          = $clog2(STRIDE + 1);
    localparam int PAD_W          = 2;
    localparam longint unsigned END_ADDR =
        longint'(HDR_BYTES) + longint'(HEIGHT) * longint'(STRIDE);

    // Elaboration-time parameter sanity checks
    if (!(PIX_PER_BEAT == 1 || PIX_PER_BEAT == 2 || PIX_PER_BEAT == 4)) begin : g_bad_ppb
        $error("image_write_stream: PIX_PER_BEAT must be 1, 2 or 4");
    end
    if ((WIDTH % PIX_PER_BEAT) != 0) begin : g_bad_width
        $error("image_write_stream: WIDTH must be a multiple of PIX_PER_BEAT");
    end
    if (END_ADDR > (64'd1 << ADDR_W)) begin : g_bad_addr
        $error("image_write_stream: pixel array does not fit in ADDR_W bits");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SER  = 3'd2,
        ST_PAD  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;

    logic [24*PIX_PER_BEAT-1:0] hold_r;
    logic [BIDX_W-1:0]        byte_idx_r;   // next byte of the held beat to emit
    logic [BEAT_W-1:0]        beat_cnt_r;   // beat index within the current row
    logic [ROW_W-1:0]         row_r;
    logic [COL_W-1:0]         colbyte_r;    // next byte offset within the row
    logic [PAD_W-1:0]         pad_idx_r;    // next pad byte index

    logic                     pix_ready_r;
    logic                     mem_we_r;
    logic [ADDR_W-1:0]        mem_addr_r;
    logic [7:0]               mem_wdata_r;
    logic                     busy_r;
    logic                     frame_done_r;
    logic [15:0]              frame_count_r;

    logic                     beat_end_s;
    logic                     row_end_s;
    logic                     last_row_s;
    logic                     pad_end_s;
    logic                     row_adv_s;
    logic [ADDR_W-1:0]        srow_s;
    logic [ADDR_W-1:0]        wr_addr_s;
    logic                     we_next_s;
    logic [ADDR_W-1:0]        addr_next_s;
    logic [7:0]               wdata_next_s;

    // Selects byte idx of a held beat; byte order B,G,R per pixel maps to ascending byte lanes
    function automatic logic [7:0] pick_byte(input logic [24*PIX_PER_BEAT-1:0] v,
                                             input logic [BIDX_W-1:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            if (idx == BIDX_W'(i)) begin
                r = v[8*i +: 8];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign beat_end_s = (byte_idx_r == BIDX_W'(BYTES_PER_BEAT));
    assign row_end_s  = (beat_cnt_r == BEAT_W'(BEATS_PER_ROW - 1));
    assign last_row_s = (row_r == ROW_W'(HEIGHT - 1));
    assign pad_end_s  = (pad_idx_r == PAD_W'(PAD_BYTES));

    // Storage row and byte address of the next write
    always_comb begin
        srow_s = '0;
        if (BOTTOM_UP != 0) begin
            srow_s = ADDR_W'(HEIGHT - 1) - ADDR_W'(row_r);
        end else begin
            srow_s = ADDR_W'(row_r);
        end
        wr_addr_s = ADDR_W'(HDR_BYTES) + srow_s * ADDR_W'(STRIDE) + ADDR_W'(colbyte_r);
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_LOAD;
                else       state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (pix_valid) state_next_s = ST_SER;
                else           state_next_s = ST_LOAD;
            end
            ST_SER: begin
                if (!beat_end_s)        state_next_s = ST_SER;
                else if (!row_end_s)    state_next_s = ST_LOAD;
                else if (PAD_BYTES > 0) state_next_s = ST_PAD;
                else if (last_row_s)    state_next_s = ST_DONE;
                else                    state_next_s = ST_LOAD;
            end
            ST_PAD: begin
                if (!pad_end_s)      state_next_s = ST_PAD;
                else if (last_row_s) state_next_s = ST_DONE;
                else                 state_next_s = ST_LOAD;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Leaving a finished (non-final) row for the next one
    assign row_adv_s = (state_next_s == ST_LOAD) &&
                       ((state_r == ST_PAD) || ((state_r == ST_SER) && row_end_s));

    // Output logic: the write presented in the next cycle (outputs are registered)
    always_comb begin
        we_next_s    = 1'b0;
        addr_next_s  = mem_addr_r;
        wdata_next_s = mem_wdata_r;
        case (state_r)
            ST_LOAD: begin
                if (pix_valid) begin
                    we_next_s    = 1'b1;
                    addr_next_s  = wr_addr_s;
                    wdata_next_s = pix_data[7:0];
                end else begin
                    we_next_s = 1'b0;
                end
            end
            ST_SER: begin
                if (!beat_end_s) begin
                    we_next_s    = 1'b1;
                    addr_next_s  = wr_addr_s;
                    wdata_next_s = pick_byte(hold_r, byte_idx_r);
                end else if (row_end_s && (PAD_BYTES > 0)) begin
                    // first pad byte goes out in the first PAD cycle
                    we_next_s    = 1'b1;
                    addr_next_s  = wr_addr_s;
                    wdata_next_s = 8'h00;
                end else begin
                    we_next_s = 1'b0;
                end
            end
            ST_PAD: begin
                if (!pad_end_s) begin
                    we_next_s    = 1'b1;
                    addr_next_s  = wr_addr_s;
                    wdata_next_s = 8'h00;
                end else begin
                    we_next_s = 1'b0;
                end
            end
            default: we_next_s = 1'b0;
        endcase
    end

    // Datapath counters and beat holding register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            hold_r     <= '0;
            byte_idx_r <= '0;
            beat_cnt_r <= '0;
            row_r      <= '0;
            colbyte_r  <= '0;
            pad_idx_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        byte_idx_r <= '0;
                        beat_cnt_r <= '0;
                        row_r      <= '0;
                        colbyte_r  <= '0;
                        pad_idx_r  <= '0;
                    end else begin
                        row_r <= row_r;
                    end
                end
                ST_LOAD: begin
                    if (pix_valid) begin
                        hold_r     <= pix_data;
                        byte_idx_r <= BIDX_W'(1);
                        colbyte_r  <= colbyte_r + COL_W'(1);
                    end else begin
                        hold_r <= hold_r;
                    end
                end
                ST_SER: begin
                    if (!beat_end_s) begin
                        byte_idx_r <= byte_idx_r + BIDX_W'(1);
                        colbyte_r  <= colbyte_r + COL_W'(1);
                    end else begin
                        byte_idx_r <= '0;
                        if (row_end_s) begin
                            beat_cnt_r <= '0;
                            pad_idx_r  <= PAD_W'(1);
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        end
                        if (row_adv_s) begin
                            colbyte_r <= '0;
                            row_r     <= row_r + ROW_W'(1);
                        end else if (we_next_s) begin
                            colbyte_r <= colbyte_r + COL_W'(1);
                        end else begin
                            colbyte_r <= colbyte_r;
                        end
                    end
                end
                ST_PAD: begin
                    if (!pad_end_s) begin
                        pad_idx_r <= pad_idx_r + PAD_W'(1);
                        colbyte_r <= colbyte_r + COL_W'(1);
                    end else if (row_adv_s) begin
                        colbyte_r <= '0;
                        row_r     <= row_r + ROW_W'(1);
                    end else begin
                        colbyte_r <= colbyte_r;
                    end
                end
                default: begin
                    row_r <= row_r;
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pix_ready_r   <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= 8'h00;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'h0000;
        end else begin
            pix_ready_r  <= (state_next_s == ST_LOAD);
            mem_we_r     <= we_next_s;
            mem_addr_r   <= addr_next_s;
            mem_wdata_r  <= wdata_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            frame_done_r <= (state_next_s == ST_DONE);
            if (state_next_s == ST_DONE) begin
                frame_count_r <= frame_count_r + 16'h0001;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign pix_ready   = pix_ready_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign frame_count = frame_count_r;

endmodule
